multicycle_control_unit: RTL and testbench



---
 rtl/ctrl_pkg.sv | 64 ++++++
 rtl/multicycle_control_unit_if.sv | 34 +++
 rtl/alu_decoder.sv | 50 +++++
 rtl/multicycle_control_unit.sv | 146 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, functs, ALU and PC
// selector codes, FSM states and trap causes.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUBU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_ADD  = 4'b1011;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  localparam logic [2:0] PC_PLUS4  = 3'b000;
  localparam logic [2:0] PC_JUMP   = 3'b001;
  localparam logic [2:0] PC_REG    = 3'b010;
  localparam logic [2:0] PC_BRANCH = 3'b011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_SB) || (opcode == OP_SH);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Datapath-facing bundle of the control unit: status inputs in, strobes out.
// The master side is the control unit; the slave side is the datapath/memories.
interface multicycle_control_unit_if;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        mem_ready;
  logic        alu_zero;
  logic [1:0]  addr_lsb;

  logic        ir_load;
  logic        pc_write;
  logic [2:0]  pc_control;
  logic        alu_mux_select;
  logic [3:0]  alu_control;
  logic [3:0]  data_mem_wren;
  logic        mem_read;
  logic        reg_file_wren;
  logic        link_select;
  logic        busy;
  logic        trap;
  logic [1:0]  trap_cause;

  modport master (
    input  instruction, instr_valid, mem_ready, alu_zero, addr_lsb,
    output ir_load, pc_write, pc_control, alu_mux_select, alu_control,
           data_mem_wren, mem_read, reg_file_wren, link_select, busy, trap, trap_cause
  );

  modport slave (
    output instruction, instr_valid, mem_ready, alu_zero, addr_lsb,
    input  ir_load, pc_write, pc_control, alu_mux_select, alu_control,
           data_mem_wren, mem_read, reg_file_wren, link_select, busy, trap, trap_cause
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decode: ALU operation, immediate-operand select and
// whether the instruction belongs to the supported set.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       alu_mux_select,
  output logic       legal
);

  always_comb begin
    alu_control    = ALU_NONE;
    alu_mux_select = 1'b0;
    legal          = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_ADDU: alu_control = ALU_ADDU;
          FN_XOR:  alu_control = ALU_XOR;
          FN_NOR:  alu_control = ALU_NOR;
          FN_SUBU: alu_control = ALU_SUBU;
          FN_SLT:  alu_control = ALU_SLT;
          FN_SLL:  alu_control = ALU_SLL;
          FN_SRL:  alu_control = ALU_SRL;
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_JR:   alu_control = ALU_NONE;
          default: legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL: legal = 1'b1;
      OP_BEQ, OP_BNE: begin
        legal       = 1'b1;
        alu_control = ALU_SUB;
      end
      OP_ADDI, OP_LW, OP_SW, OP_SB, OP_SH: begin
        legal          = 1'b1;
        alu_control    = ALU_ADD;
        alu_mux_select = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready handshake,
// sub-word store lane enables and an illegal-instruction/timeout trap.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input logic                        clk,
  input logic                        reset,
  multicycle_control_unit_if.master  bus
);

  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_t               state, next_state;
  logic [31:0]          ir;
  logic [TIMEOUT_W-1:0] mem_count;
  logic [1:0]           cause, next_cause;

  logic [5:0] opcode, funct;
  logic [3:0] dec_alu;
  logic       dec_mux, dec_legal;
  logic       unused_ir_bits;

  assign opcode         = ir[31:26];
  assign funct          = ir[5:0];
  assign unused_ir_bits = ^ir[25:6];

  alu_decoder u_alu_decoder (
    .opcode         (opcode),
    .funct          (funct),
    .alu_control    (dec_alu),
    .alu_mux_select (dec_mux),
    .legal          (dec_legal)
  );

  // The wait counter is held at zero outside MEM so every MEM entry starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      ir        <= '0;
      mem_count <= '0;
      cause     <= CAUSE_NONE;
    end else begin
      state <= next_state;
      cause <= next_cause;
      if (bus.ir_load) ir <= bus.instruction;
      if (state != MEM) mem_count <= '0;
      else if (!bus.mem_ready) mem_count <= mem_count + 1'b1;
    end
  end

  always_comb begin
    next_state         = state;
    next_cause         = cause;
    bus.ir_load        = 1'b0;
    bus.pc_write       = 1'b0;
    bus.pc_control     = PC_PLUS4;
    bus.alu_mux_select = 1'b0;
    bus.alu_control    = ALU_NONE;
    bus.data_mem_wren  = 4'b0000;
    bus.mem_read       = 1'b0;
    bus.reg_file_wren  = 1'b0;
    bus.link_select    = 1'b0;
    bus.busy           = (state != FETCH);
    bus.trap           = (state == TRAP);
    bus.trap_cause     = cause;

    if (state inside {DECODE, EXEC, MEM, WB}) begin
      bus.alu_control    = dec_alu;
      bus.alu_mux_select = dec_mux;
    end

    case (state)
      FETCH: begin
        if (bus.instr_valid) begin
          bus.ir_load  = 1'b1;
          bus.pc_write = 1'b1;
          next_state   = DECODE;
        end
      end
      DECODE: begin
        if (dec_legal) begin
          next_state = EXEC;
        end else begin
          next_state = TRAP;
          next_cause = CAUSE_ILLEGAL;
        end
      end
      EXEC: begin
        next_state = WB;
        case (opcode)
          OP_J, OP_JAL: begin
            bus.pc_write   = 1'b1;
            bus.pc_control = PC_JUMP;
            next_state     = (opcode == OP_JAL) ? WB : FETCH;
          end
          OP_BEQ, OP_BNE: begin
            bus.pc_write   = (opcode == OP_BEQ) ? bus.alu_zero : !bus.alu_zero;
            bus.pc_control = bus.pc_write ? PC_BRANCH : PC_PLUS4;
            next_state     = FETCH;
          end
          OP_RTYPE: begin
            if (funct == FN_JR) begin
              bus.pc_write   = 1'b1;
              bus.pc_control = PC_REG;
              next_state     = FETCH;
            end
          end
          default: begin
            if (is_mem_op(opcode)) next_state = MEM;
          end
        endcase
      end
      // Strobes stay asserted for the whole wait; the timeout trips on the
      // MEM_TIMEOUT-th consecutive cycle without mem_ready.
      MEM: begin
        case (opcode)
          OP_LW:   bus.mem_read      = 1'b1;
          OP_SW:   bus.data_mem_wren = 4'b1111;
          OP_SH:   bus.data_mem_wren = 4'b0011 << {bus.addr_lsb[1], 1'b0};
          OP_SB:   bus.data_mem_wren = 4'b0001 << bus.addr_lsb;
          default: bus.data_mem_wren = 4'b0000;
        endcase
        if (bus.mem_ready) begin
          next_state = (opcode == OP_LW) ? WB : FETCH;
        end else if (mem_count == LAST_WAIT) begin
          next_state = TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      WB: begin
        bus.reg_file_wren = 1'b1;
        bus.link_select   = (opcode == OP_JAL);
        next_state        = FETCH;
      end
      TRAP: begin
        bus.alu_control    = ALU_NONE;
        bus.alu_mux_select = 1'b0;
      end
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-by-cycle scoreboard bench for multicycle_control_unit (MEM_TIMEOUT = 4).
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(.TIMEOUT_W(8), .MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q [$];
  string       tag_q [$];

  logic [5:0] r_funct [11] = '{6'h24, 6'h25, 6'h21, 6'h26, 6'h27, 6'h23, 6'h22, 6'h20, 6'h2A, 6'h00, 6'h02};
  logic [3:0] r_alu   [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'hC, 4'hB, 4'h7, 4'h8, 4'h9};
  string      r_name  [11] = '{"and", "or", "addu", "xor", "nor", "subu", "sub", "add", "slt", "sll", "srl"};

  // Field order: ir_load pc_write pc_control mux alu wren mem_read rf_wren link busy trap cause
  function automatic logic [20:0] ev(input logic irl, input logic pcw, input logic [2:0] pcc,
                                     input logic mux, input logic [3:0] alu, input logic [3:0] wren,
                                     input logic mrd, input logic rfw, input logic lnk,
                                     input logic bsy, input logic trp, input logic [1:0] cause);
    return {irl, pcw, pcc, mux, alu, wren, mrd, rfw, lnk, bsy, trp, cause};
  endfunction

  function automatic logic [20:0] bz(input logic mux, input logic [3:0] alu);
    return ev(1'b0, 1'b0, 3'b000, mux, alu, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
  endfunction

  function automatic logic [20:0] observed();
    return {bus.ir_load, bus.pc_write, bus.pc_control, bus.alu_mux_select, bus.alu_control,
            bus.data_mem_wren, bus.mem_read, bus.reg_file_wren, bus.link_select,
            bus.busy, bus.trap, bus.trap_cause};
  endfunction

  task automatic checkOutput(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rst, input logic [31:0] instr,
                               input logic iv, input logic az, input logic rdy,
                               input logic [1:0] lsb, input logic [20:0] exp);
    reset           = rst;
    bus.instruction = instr;
    bus.instr_valid = iv;
    bus.alu_zero    = az;
    bus.mem_ready   = rdy;
    bus.addr_lsb    = lsb;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    checkOutput(tag_q.pop_front(), observed(), exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] instr);
    applyStimulus({tag, ".fetch"}, 1'b0, instr, 1'b1, 1'b0, 1'b0, 2'b00,
                  ev(1'b1, 1'b1, 3'b000, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
  endtask

  // Garbage instruction and asserted instr_valid outside FETCH must be ignored.
  task automatic step(input string tag, input logic az, input logic rdy, input logic [1:0] lsb,
                      input logic [20:0] exp);
    applyStimulus(tag, 1'b0, 32'hFFFF_FFFF, 1'b1, az, rdy, lsb, exp);
  endtask

  task automatic idle(input string tag);
    applyStimulus({tag, ".idle"}, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00,
                  ev(1'b0, 1'b0, 3'b000, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
  endtask

  task automatic resetCycle(input string tag, input logic [20:0] exp);
    applyStimulus({tag, ".reset"}, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, exp);
  endtask

  task automatic storeOp(input string tag, input logic [31:0] instr, input logic [1:0] lsb,
                         input int waits, input logic [3:0] wren);
    logic [20:0] mv;
    mv = ev(1'b0, 1'b0, 3'b000, 1'b1, 4'hB, wren, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    fetch(tag, instr);
    step({tag, ".decode"}, 1'b0, 1'b1, lsb, bz(1'b1, 4'hB));
    step({tag, ".exec"}, 1'b0, 1'b1, lsb, bz(1'b1, 4'hB));
    for (int w = 0; w < waits; w++) step({tag, ".memwait"}, 1'b0, 1'b0, lsb, mv);
    step({tag, ".memdone"}, 1'b0, 1'b1, lsb, mv);
    idle(tag);
  endtask

  task automatic branchOp(input string tag, input logic [31:0] instr, input logic az, input logic taken);
    fetch(tag, instr);
    step({tag, ".decode"}, ~az, 1'b1, 2'b00, bz(1'b0, 4'hC));
    step({tag, ".exec"}, az, 1'b1, 2'b00,
         ev(1'b0, taken, taken ? 3'b011 : 3'b000, 1'b0, 4'hC, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    idle(tag);
  endtask

  initial begin
    logic [20:0] trap01, trap10, lwmem;
    trap01 = ev(1'b0, 1'b0, 3'b000, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
    trap10 = ev(1'b0, 1'b0, 3'b000, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    lwmem  = ev(1'b0, 1'b0, 3'b000, 1'b1, 4'hB, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);

    reset = 1'b1;
    bus.instruction = 32'h0;
    bus.instr_valid = 1'b0;
    bus.alu_zero    = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.addr_lsb    = 2'b00;
    @(posedge clk);
    #1;
    resetCycle("init", ev(1'b0, 1'b0, 3'b000, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    idle("init");

    for (int i = 0; i < 11; i++) begin
      fetch(r_name[i], {26'h0088C60, r_funct[i]});
      step({r_name[i], ".decode"}, 1'b1, 1'b1, 2'b00, bz(1'b0, r_alu[i]));
      step({r_name[i], ".exec"}, 1'b1, 1'b1, 2'b00, bz(1'b0, r_alu[i]));
      step({r_name[i], ".wb"}, 1'b1, 1'b1, 2'b00,
           ev(1'b0, 1'b0, 3'b000, 1'b0, r_alu[i], 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00));
      idle(r_name[i]);
    end

    fetch("addi", 32'h2022_0005);
    step("addi.decode", 1'b0, 1'b0, 2'b00, bz(1'b1, 4'hB));
    step("addi.exec", 1'b0, 1'b0, 2'b00, bz(1'b1, 4'hB));
    step("addi.wb", 1'b0, 1'b0, 2'b00,
         ev(1'b0, 1'b0, 3'b000, 1'b1, 4'hB, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00));
    idle("addi");

    fetch("j", 32'h0800_0010);
    step("j.decode", 1'b0, 1'b0, 2'b00, bz(1'b0, 4'hF));
    step("j.exec", 1'b0, 1'b0, 2'b00,
         ev(1'b0, 1'b1, 3'b001, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    idle("j");

    fetch("jal", 32'h0C00_0010);
    step("jal.decode", 1'b0, 1'b0, 2'b00, bz(1'b0, 4'hF));
    step("jal.exec", 1'b0, 1'b0, 2'b00,
         ev(1'b0, 1'b1, 3'b001, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    step("jal.wb", 1'b0, 1'b0, 2'b00,
         ev(1'b0, 1'b0, 3'b000, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00));
    idle("jal");

    fetch("jr", 32'h03E0_0008);
    step("jr.decode", 1'b0, 1'b0, 2'b00, bz(1'b0, 4'hF));
    step("jr.exec", 1'b0, 1'b0, 2'b00,
         ev(1'b0, 1'b1, 3'b010, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    idle("jr");

    branchOp("beq_taken", 32'h1022_0003, 1'b1, 1'b1);
    branchOp("beq_not", 32'h1022_0003, 1'b0, 1'b0);
    branchOp("bne_taken", 32'h1422_0003, 1'b0, 1'b1);
    branchOp("bne_not", 32'h1422_0003, 1'b1, 1'b0);

    storeOp("sb_lsb2", 32'hA022_0004, 2'b10, 3, 4'b0100);
    storeOp("sb_lsb1", 32'hA022_0004, 2'b01, 0, 4'b0010);
    storeOp("sh_lsb2", 32'hA422_0004, 2'b10, 0, 4'b1100);
    storeOp("sh_lsb1", 32'hA422_0004, 2'b01, 1, 4'b0011);
    storeOp("sw", 32'hAC22_0004, 2'b11, 0, 4'b1111);

    fetch("lw", 32'h8C22_0004);
    step("lw.decode", 1'b0, 1'b1, 2'b00, bz(1'b1, 4'hB));
    step("lw.exec", 1'b0, 1'b1, 2'b00, bz(1'b1, 4'hB));
    step("lw.memwait", 1'b0, 1'b0, 2'b00, lwmem);
    step("lw.memdone", 1'b0, 1'b1, 2'b00, lwmem);
    step("lw.wb", 1'b0, 1'b1, 2'b00,
         ev(1'b0, 1'b0, 3'b000, 1'b1, 4'hB, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00));
    idle("lw");

    fetch("lw_timeout", 32'h8C22_0004);
    step("lw_timeout.decode", 1'b0, 1'b0, 2'b00, bz(1'b1, 4'hB));
    step("lw_timeout.exec", 1'b0, 1'b0, 2'b00, bz(1'b1, 4'hB));
    for (int w = 0; w < 4; w++) step("lw_timeout.memwait", 1'b0, 1'b0, 2'b00, lwmem);
    step("lw_timeout.trap", 1'b0, 1'b1, 2'b00, trap10);
    step("lw_timeout.trap_hold", 1'b1, 1'b1, 2'b11, trap10);
    resetCycle("lw_timeout", trap10);
    idle("lw_timeout");

    fetch("illegal_op", 32'hFC00_0000);
    step("illegal_op.decode", 1'b0, 1'b0, 2'b00, bz(1'b0, 4'hF));
    step("illegal_op.trap", 1'b0, 1'b1, 2'b00, trap01);
    step("illegal_op.trap_hold", 1'b1, 1'b1, 2'b00, trap01);
    resetCycle("illegal_op", trap01);
    idle("illegal_op");

    fetch("illegal_fn", 32'h0000_0001);
    step("illegal_fn.decode", 1'b0, 1'b0, 2'b00, bz(1'b0, 4'hF));
    step("illegal_fn.trap", 1'b0, 1'b0, 2'b00, trap01);
    resetCycle("illegal_fn", trap01);
    idle("illegal_fn");

    fetch("sw_reset", 32'hAC22_0004);
    step("sw_reset.decode", 1'b0, 1'b0, 2'b00, bz(1'b1, 4'hB));
    step("sw_reset.exec", 1'b0, 1'b0, 2'b00, bz(1'b1, 4'hB));
    step("sw_reset.memwait", 1'b0, 1'b0, 2'b00,
         ev(1'b0, 1'b0, 3'b000, 1'b1, 4'hB, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    resetCycle("sw_reset",
               ev(1'b0, 1'b0, 3'b000, 1'b1, 4'hB, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    idle("sw_reset");
    storeOp("sw_after_reset", 32'hAC22_0004, 2'b00, 3, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
